// File: rtl/pc_sequencer.sv
// pc_sequencer
// Program-counter sequencer for a 16-bit instruction stream with 2-byte
// instructions. It decodes branch (B), register branch (BR) and halt (HLT)
// opcodes, evaluates branch conditions against the {V,N,Z} flags and keeps
// a saturating count of taken branches.
//
// Ports
//   clk          rising-edge clock for all state
//   rst          synchronous, active-high reset
//   stall        hazard hold; the PC does not advance while high
//   instr_valid  instr is a real instruction located at pc_addr
//   instr        opcode [15:12], cond [11:9], imm [IMM_W-1:0]
//   flags        {V,N,Z}
//   reg_target   register-indirect branch target
//   pc_addr      registered fetch address
//   pc_next_seq  pc_addr + 2 (combinational)
//   flush        one-cycle pulse in the cycle after a taken redirect
//   halted       high while in the HALT state
//   taken_count  saturating count of taken branches
module pc_sequencer #(
  parameter int unsigned              ADDR_W     = 16,
  parameter int unsigned              IMM_W      = 9,
  parameter logic [ADDR_W-1:0]        RESET_ADDR = {ADDR_W{1'b0}},
  parameter int unsigned              CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  input  logic [2:0]        flags,
  input  logic [ADDR_W-1:0] reg_target,
  output logic [ADDR_W-1:0] pc_addr,
  output logic [ADDR_W-1:0] pc_next_seq,
  output logic              flush,
  output logic              halted,
  output logic [CNT_W-1:0]  taken_count
);

  localparam logic [3:0]        OP_B     = 4'b1100;
  localparam logic [3:0]        OP_BR    = 4'b1101;
  localparam logic [3:0]        OP_HLT   = 4'b1111;
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(2);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [ADDR_W-1:0]   pc_next_s;
  logic                flush_next_s;
  logic [CNT_W-1:0]    count_next_s;
  logic                cond_pass_s;
  logic [ADDR_W-1:0]   imm_ext_s;
  logic [ADDR_W-1:0]   b_target_s;
  logic [3:0]          opcode_s;
  logic [2:0]          cond_s;
  logic                flag_z_s;
  logic                flag_n_s;
  logic                flag_v_s;

  assign opcode_s    = instr[15:12];
  assign cond_s      = instr[11:9];
  assign flag_z_s    = flags[0];
  assign flag_n_s    = flags[1];
  assign flag_v_s    = flags[2];
  assign pc_next_seq = pc_addr + PC_STEP;
  assign halted      = (state_r == ST_HALT);

  // Sign-extended immediate scaled to a byte offset; wraps modulo 2^ADDR_W.
  assign imm_ext_s  = {{(ADDR_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
  assign b_target_s = pc_next_seq + {imm_ext_s[ADDR_W-2:0], 1'b0};

  // Branch condition evaluation against the current flags.
  always_comb begin
    cond_pass_s = 1'b0;
    case (cond_s)
      3'b000:  cond_pass_s = ~flag_z_s;
      3'b001:  cond_pass_s = flag_z_s;
      3'b010:  cond_pass_s = ~flag_z_s & ~flag_n_s;
      3'b011:  cond_pass_s = flag_n_s;
      3'b100:  cond_pass_s = flag_z_s | ~flag_n_s;
      3'b101:  cond_pass_s = flag_n_s | flag_z_s;
      3'b110:  cond_pass_s = flag_v_s;
      3'b111:  cond_pass_s = 1'b1;
      default: cond_pass_s = 1'b0;
    endcase
  end

  // Next-state, next-PC, flush and counter decisions.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_addr;
    flush_next_s = 1'b0;
    count_next_s = taken_count;
    case (state_r)
      ST_RUN: begin
        if (stall) begin
          // A stalled branch stays unresolved; flags are re-read next cycle.
          pc_next_s = pc_addr;
        end else if (!instr_valid) begin
          pc_next_s = pc_next_seq;
        end else if (opcode_s == OP_HLT) begin
          state_next_s = ST_HALT;
          pc_next_s    = pc_addr;
        end else if (((opcode_s == OP_B) || (opcode_s == OP_BR)) && cond_pass_s) begin
          if (opcode_s == OP_BR) begin
            pc_next_s = reg_target;
          end else begin
            pc_next_s = b_target_s;
          end
          flush_next_s = 1'b1;
          if (taken_count != CNT_MAX) begin
            count_next_s = taken_count + CNT_ONE;
          end else begin
            count_next_s = taken_count;
          end
        end else begin
          pc_next_s = pc_next_seq;
        end
      end
      ST_HALT: begin
        // Only rst leaves HALT; everything holds and flush stays low.
        state_next_s = ST_HALT;
      end
      default: begin
        state_next_s = ST_HALT;
      end
    endcase
  end

  // State, PC, flush and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_RUN;
      pc_addr     <= RESET_ADDR;
      flush       <= 1'b0;
      taken_count <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_next_s;
      pc_addr     <= pc_next_s;
      flush       <= flush_next_s;
      taken_count <= count_next_s;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a default-parameter instance plus a
// CNT_W=2 instance sharing all inputs, checked after each rising edge.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        instr_valid;
  logic [15:0] instr;
  logic [2:0]  flags;
  logic [15:0] reg_target;
  logic [15:0] pc_addr;
  logic [15:0] pc_next_seq;
  logic        flush;
  logic        halted;
  logic [15:0] taken_count;
  logic [15:0] pc_addr2;
  logic [15:0] pc_next_seq2;
  logic        flush2;
  logic        halted2;
  logic [1:0]  taken_count2;

  int errors;
  int checks;
  logic [15:0] exp_pc;
  logic [15:0] exp_cnt;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .instr_valid(instr_valid),
    .instr(instr), .flags(flags), .reg_target(reg_target),
    .pc_addr(pc_addr), .pc_next_seq(pc_next_seq), .flush(flush),
    .halted(halted), .taken_count(taken_count)
  );

  pc_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .instr_valid(instr_valid),
    .instr(instr), .flags(flags), .reg_target(reg_target),
    .pc_addr(pc_addr2), .pc_next_seq(pc_next_seq2), .flush(flush2),
    .halted(halted2), .taken_count(taken_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [15:0] pc, input logic fl,
                           input logic hl, input logic [15:0] cnt);
    chk({tag, ".pc"}, {16'h0000, pc_addr}, {16'h0000, pc});
    chk({tag, ".flush"}, {31'h0, flush}, {31'h0, fl});
    chk({tag, ".halted"}, {31'h0, halted}, {31'h0, hl});
    chk({tag, ".count"}, {16'h0000, taken_count}, {16'h0000, cnt});
  endtask

  // Condition table: cond, flags {V,N,Z}, hand-derived taken bit.
  logic [2:0] tc_cond  [10] = '{3'b000, 3'b000, 3'b010, 3'b010, 3'b011,
                                3'b100, 3'b100, 3'b101, 3'b110, 3'b110};
  logic [2:0] tc_flags [10] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b010,
                                3'b010, 3'b011, 3'b001, 3'b100, 3'b011};
  logic       tc_taken [10] = '{1'b0,   1'b1,   1'b0,   1'b1,   1'b1,
                                1'b0,   1'b1,   1'b1,   1'b1,   1'b0};
  logic [1:0] exp_sat  [5]  = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; stall = 1'b0; instr_valid = 1'b0; instr = 16'h0000;
    flags = 3'b000; reg_target = 16'h0000;
    step();
    rst = 1'b0;
    chk_state("reset", 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("reset.seq", {16'h0, pc_next_seq}, 32'h0000_0002);

    // Sequential fetch from reset.
    instr_valid = 1'b1; instr = 16'h0000;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk_state("seq", 16'(2 * i), 1'b0, 1'b0, 16'h0000);
    end
    for (int i = 0; i < 4; i++) step();
    chk("seq.pc10", {16'h0, pc_addr}, 32'h0000_0010);

    // B always, imm=-4 at 0x0010 -> 0x000A.
    instr = 16'hCFFC;
    step();
    chk_state("b_neg", 16'h000A, 1'b1, 1'b0, 16'h0001);
    instr = 16'h0000;
    step();
    chk_state("b_neg.after", 16'h000C, 1'b0, 1'b0, 16'h0001);

    // BR to 0x0020, then B cond=001 with Z=0 (not taken).
    instr = 16'hDE00; reg_target = 16'h0020;
    step();
    chk_state("br20", 16'h0020, 1'b1, 1'b0, 16'h0002);
    instr = 16'hC200; flags = 3'b000;
    step();
    chk_state("beq_nt", 16'h0022, 1'b0, 1'b0, 16'h0002);
    instr = 16'hDE00;
    step();
    chk_state("br20b", 16'h0020, 1'b1, 1'b0, 16'h0003);
    instr = 16'hC203; flags = 3'b001;
    step();
    chk_state("beq_t", 16'h0028, 1'b1, 1'b0, 16'h0004);

    // Condition table with imm=1: taken -> pc+4, not taken -> pc+2.
    exp_pc = 16'h0028; exp_cnt = 16'h0004;
    for (int i = 0; i < 10; i++) begin
      instr = {4'b1100, tc_cond[i], 9'h001}; flags = tc_flags[i];
      step();
      exp_pc  = tc_taken[i] ? exp_pc + 16'h0004 : exp_pc + 16'h0002;
      exp_cnt = tc_taken[i] ? exp_cnt + 16'h0001 : exp_cnt;
      chk_state($sformatf("cond%0d", i), exp_pc, tc_taken[i], 1'b0, exp_cnt);
    end

    // Full 4-bit opcode decode: 0100 and 1110 are sequential; invalid branch too.
    instr = 16'h4E01;
    step(); exp_pc = exp_pc + 16'h0002;
    chk_state("op0100", exp_pc, 1'b0, 1'b0, exp_cnt);
    instr = 16'hEE01;
    step(); exp_pc = exp_pc + 16'h0002;
    chk_state("op1110", exp_pc, 1'b0, 1'b0, exp_cnt);
    instr = 16'hDE00; reg_target = 16'h1234; instr_valid = 1'b0;
    step(); exp_pc = exp_pc + 16'h0002;
    chk_state("invalid_br", exp_pc, 1'b0, 1'b0, exp_cnt);
    instr_valid = 1'b1;

    // Stalled branch resolves with the flags of the unstalled cycle.
    instr = 16'hC201; flags = 3'b001; stall = 1'b1;
    step();
    chk_state("stall_beq", exp_pc, 1'b0, 1'b0, exp_cnt);
    stall = 1'b0; flags = 3'b000;
    step(); exp_pc = exp_pc + 16'h0002;
    chk_state("stall_beq.res", exp_pc, 1'b0, 1'b0, exp_cnt);

    // BR to 0xFFFE held by 2 stall cycles, then wrap.
    instr = 16'hDE00; reg_target = 16'hFFFE; stall = 1'b1;
    step();
    chk_state("br_stall1", exp_pc, 1'b0, 1'b0, exp_cnt);
    step();
    chk_state("br_stall2", exp_pc, 1'b0, 1'b0, exp_cnt);
    stall = 1'b0;
    step(); exp_cnt = exp_cnt + 16'h0001;
    chk_state("br_fffe", 16'hFFFE, 1'b1, 1'b0, exp_cnt);
    chk("wrap.seq", {16'h0, pc_next_seq}, 32'h0000_0000);
    instr = 16'h0000;
    step();
    chk_state("wrap", 16'h0000, 1'b0, 1'b0, exp_cnt);

    // HLT at 0x0040, random inputs while halted, then reset.
    instr = 16'hDE00; reg_target = 16'h0040;
    step(); exp_cnt = exp_cnt + 16'h0001;
    chk_state("br40", 16'h0040, 1'b1, 1'b0, exp_cnt);
    instr = 16'hF000;
    step();
    chk_state("hlt", 16'h0040, 1'b0, 1'b1, exp_cnt);
    for (int i = 0; i < 10; i++) begin
      stall = 1'($urandom); instr_valid = 1'($urandom);
      instr = 16'($urandom); flags = 3'($urandom); reg_target = 16'($urandom);
      if (i % 2 == 0) instr = 16'hDE00;
      step();
      chk_state("halt_hold", 16'h0040, 1'b0, 1'b1, exp_cnt);
    end
    rst = 1'b1; instr = 16'hDE00; stall = 1'b0; instr_valid = 1'b1; flags = 3'b111;
    step();
    chk_state("halt_rst", 16'h0000, 1'b0, 1'b0, 16'h0000);
    rst = 1'b0;

    // Back-to-back taken branches; small counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      instr = 16'hDE00; reg_target = 16'(16'h0100 + 16'(i * 16));
      step();
      chk_state("b2b", 16'(16'h0100 + 16'(i * 16)), 1'b1, 1'b0, 16'(i + 1));
      chk("b2b.sat", {30'h0, taken_count2}, {30'h0, exp_sat[i]});
    end

    // Reset beats a pending branch.
    rst = 1'b1;
    step();
    chk_state("rst_prio", 16'h0000, 1'b0, 1'b0, 16'h0000);
    chk("rst_prio.sat", {30'h0, taken_count2}, 32'h0000_0000);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
